packet_frame_checker: RTL and testbench

//  In-line framing checker on the packet sink stream (valid/data/byte_enable/sop/eop),

---
 rtl/packet_pkg.sv | 20 ++
 rtl/packet_be_decode.sv | 26 ++
 rtl/packet_frame_checker.sv | 154 +++++++++++++++
 tb/tb_packet_frame_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_pkg.sv
// Shared widths, error bit indices and FSM state type for the packet framing checker.
// Imported by packet_be_decode and packet_frame_checker.
package packet_pkg;

    localparam int PACKET_WIDTH_BITS      = 64;
    localparam int BYTE_WIDTH_BITS        = 8;
    localparam int BYTE_ENABLE_WIDTH_BITS = PACKET_WIDTH_BITS / BYTE_WIDTH_BITS;
    localparam int BEAT_CNT_W             = $clog2(BYTE_ENABLE_WIDTH_BITS + 1);

    localparam int ERR_BAD_BE   = 0;
    localparam int ERR_OVERSIZE = 1;

    typedef logic [1:0] frame_err_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

endpackage

// File: rtl/packet_be_decode.sv
// Combinational byte-enable decode: number of set enables and whether they
// form an MSB-aligned contiguous run (be=0 is not contiguous).
// Ports: be (in), count (out, popcount of be), contiguous (out).
module packet_be_decode
    import packet_pkg::*;
(
    input  logic [BYTE_ENABLE_WIDTH_BITS-1:0] be,
    output logic [BEAT_CNT_W-1:0]             count,
    output logic                              contiguous
);

    always_comb begin
        count = '0;
        for (int i = 0; i < BYTE_ENABLE_WIDTH_BITS; i++) begin
            count = count + BEAT_CNT_W'(be[i]);
        end
    end

    // Every set bit must have its upper neighbour set, so the only
    // 1->0 transition (scanning down from the MSB) sits at the top.
    localparam logic [BYTE_ENABLE_WIDTH_BITS-1:0] TOP =
        {1'b1, {(BYTE_ENABLE_WIDTH_BITS-1){1'b0}}};

    assign contiguous = ((be & ~(be >> 1)) == TOP);

endmodule

// File: rtl/packet_frame_checker.sv
// In-line framing checker: forwards in-packet beats with one register of latency,
// drops orphan beats, measures packet length, flags framing errors, keeps stats.
// Ports: clk, rst_n, in_* sink stream, out_* forwarded stream, stat_* per-packet
// status pulse, clear_stats, and four saturating statistics counters.
module packet_frame_checker
    import packet_pkg::*;
#(
    parameter int MAX_PKT_BYTES = 1518,
    parameter int LEN_W         = 16,
    parameter int CNT_W         = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [PACKET_WIDTH_BITS-1:0]      in_data,
    input  logic [BYTE_ENABLE_WIDTH_BITS-1:0] in_byte_enable,
    input  logic                              in_sop,
    input  logic                              in_eop,
    output logic                              out_valid,
    output logic [PACKET_WIDTH_BITS-1:0]      out_data,
    output logic [BYTE_ENABLE_WIDTH_BITS-1:0] out_byte_enable,
    output logic                              out_sop,
    output logic                              out_eop,
    output logic                              stat_valid,
    output logic [LEN_W-1:0]                  stat_len,
    output frame_err_t                        stat_err,
    input  logic                              clear_stats,
    output logic [CNT_W-1:0]                  pkt_count,
    output logic [CNT_W-1:0]                  err_pkt_count,
    output logic [CNT_W-1:0]                  orphan_count,
    output logic [CNT_W-1:0]                  abort_count
);

    localparam logic [LEN_W:0] MAX_L = (LEN_W+1)'(MAX_PKT_BYTES);

    state_t state_q, state_d;

    logic [LEN_W-1:0]      len_q;
    logic                  bad_q;
    logic                  over_q;
    logic [BEAT_CNT_W-1:0] beat_bytes;
    logic                  contig;

    packet_be_decode u_be_decode (
        .be         (in_byte_enable),
        .count      (beat_bytes),
        .contiguous (contig)
    );

    logic in_pkt;
    logic fwd;
    logic orphan;
    logic abort;
    logic close;

    assign in_pkt = (state_q == IN_PKT);
    assign fwd    = in_valid && (in_sop || in_pkt);
    assign orphan = in_valid && !in_pkt && !in_sop;
    assign abort  = in_valid && in_pkt && in_sop;
    assign close  = fwd && in_eop;

    // A sop beat restarts accumulation, including after an abort.
    logic [LEN_W-1:0] base_len;
    logic [LEN_W:0]   sum;
    logic [LEN_W-1:0] len_next;
    logic             beat_bad;
    logic             bad_next;
    logic             over_next;
    frame_err_t       err_next;

    assign base_len  = in_sop ? '0 : len_q;
    assign sum       = {1'b0, base_len} + (LEN_W+1)'(beat_bytes);
    assign len_next  = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
    assign beat_bad  = in_eop ? !contig : (in_byte_enable != '1);
    assign bad_next  = (!in_sop && bad_q) || beat_bad;
    assign over_next = (!in_sop && over_q) || (sum > MAX_L);

    always_comb begin
        err_next               = '0;
        err_next[ERR_BAD_BE]   = bad_next;
        err_next[ERR_OVERSIZE] = over_next;
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            unique case (state_q)
                IDLE:    if (in_sop && !in_eop) state_d = IN_PKT;
                IN_PKT:  if (in_eop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    function automatic logic [CNT_W-1:0] bump(
        input logic [CNT_W-1:0] c,
        input logic             en
    );
        return (en && (c != '1)) ? c + CNT_W'(1) : c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q           <= '0;
            bad_q           <= 1'b0;
            over_q          <= 1'b0;
            out_valid       <= 1'b0;
            out_data        <= '0;
            out_byte_enable <= '0;
            out_sop         <= 1'b0;
            out_eop         <= 1'b0;
            stat_valid      <= 1'b0;
            stat_len        <= '0;
            stat_err        <= '0;
            pkt_count       <= '0;
            err_pkt_count   <= '0;
            orphan_count    <= '0;
            abort_count     <= '0;
        end else begin
            out_valid  <= fwd;
            out_sop    <= fwd && in_sop;
            out_eop    <= close;
            stat_valid <= close;
            if (fwd) begin
                len_q           <= len_next;
                bad_q           <= bad_next;
                over_q          <= over_next;
                out_data        <= in_data;
                out_byte_enable <= in_byte_enable;
            end
            if (close) begin
                stat_len <= len_next;
                stat_err <= err_next;
            end
            if (clear_stats) begin
                pkt_count     <= '0;
                err_pkt_count <= '0;
                orphan_count  <= '0;
                abort_count   <= '0;
            end else begin
                pkt_count     <= bump(pkt_count, close);
                err_pkt_count <= bump(err_pkt_count, close && (err_next != '0));
                orphan_count  <= bump(orphan_count, orphan);
                abort_count   <= bump(abort_count, abort);
            end
        end
    end

endmodule

// File: tb/tb_packet_frame_checker.sv
// Directed scoreboard bench for packet_frame_checker (MAX_PKT_BYTES=16).
// Expected beats/status are queued at drive time and popped at the output.
module tb_packet_frame_checker;

    localparam int MAXB = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_byte_enable;
    logic        in_sop;
    logic        in_eop;
    logic        out_valid;
    logic [63:0] out_data;
    logic [7:0]  out_byte_enable;
    logic        out_sop;
    logic        out_eop;
    logic        stat_valid;
    logic [15:0] stat_len;
    logic [1:0]  stat_err;
    logic        clear_stats;
    logic [31:0] pkt_count;
    logic [31:0] err_pkt_count;
    logic [31:0] orphan_count;
    logic [31:0] abort_count;

    packet_frame_checker #(
        .MAX_PKT_BYTES (MAXB),
        .LEN_W         (16),
        .CNT_W         (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_byte_enable  (in_byte_enable),
        .in_sop          (in_sop),
        .in_eop          (in_eop),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_byte_enable (out_byte_enable),
        .out_sop         (out_sop),
        .out_eop         (out_eop),
        .stat_valid      (stat_valid),
        .stat_len        (stat_len),
        .stat_err        (stat_err),
        .clear_stats     (clear_stats),
        .pkt_count       (pkt_count),
        .err_pkt_count   (err_pkt_count),
        .orphan_count    (orphan_count),
        .abort_count     (abort_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  be;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct packed {
        logic [15:0] len;
        logic [1:0]  err;
    } stat_t;

    beat_t exp_q[$];
    stat_t st_q[$];

    int checks = 0;
    int errors = 0;

    bit m_in_pkt;
    int m_len;
    bit m_bad;
    int m_pkt, m_err, m_orphan, m_abort;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int popc(input logic [7:0] be);
        int n = 0;
        for (int i = 0; i < 8; i++) if (be[i]) n++;
        return n;
    endfunction

    function automatic bit is_contig(input logic [7:0] be);
        case (be)
            8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic monitor();
        beat_t b;
        stat_t s;
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        chk("stat_valid", 64'(stat_valid), 64'(st_q.size() > 0));
        chk("stat_with_eop", 64'(stat_valid), 64'(out_valid && out_eop));
        if (!out_valid) chk("idle_sop_eop", 64'({out_sop, out_eop}), 64'(0));
        if (out_valid && exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk("out_data", out_data, b.data);
            chk("out_be", 64'(out_byte_enable), 64'(b.be));
            chk("out_sop", 64'(out_sop), 64'(b.sop));
            chk("out_eop", 64'(out_eop), 64'(b.eop));
        end
        if (stat_valid && st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("stat_len", 64'(stat_len), 64'(s.len));
            chk("stat_err", 64'(stat_err), 64'(s.err));
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic check_counts();
        chk("pkt_count", 64'(pkt_count), 64'(m_pkt));
        chk("err_pkt_count", 64'(err_pkt_count), 64'(m_err));
        chk("orphan_count", 64'(orphan_count), 64'(m_orphan));
        chk("abort_count", 64'(abort_count), 64'(m_abort));
    endtask

    task automatic send(input logic [7:0] be, input logic s, input logic e,
                        input logic clr = 1'b0);
        logic [63:0] d;
        bit fwd;
        d = {$urandom, $urandom};
        fwd = s || m_in_pkt;
        if (!fwd) m_orphan++;
        if (s && m_in_pkt) m_abort++;
        if (fwd) begin
            if (s) begin
                m_len = 0;
                m_bad = 0;
            end
            m_len += popc(be);
            if (e) m_bad |= (be == 8'h00) || !is_contig(be);
            else   m_bad |= (be != 8'hFF);
            exp_q.push_back('{data: d, be: be, sop: s, eop: e});
            if (e) begin
                st_q.push_back('{len: 16'((m_len > 65535) ? 65535 : m_len),
                                 err: {(m_len > MAXB), m_bad}});
                m_pkt++;
                if (m_bad || m_len > MAXB) m_err++;
            end
            m_in_pkt = !e;
        end
        if (clr) begin
            m_pkt = 0;
            m_err = 0;
            m_orphan = 0;
            m_abort = 0;
        end
        in_valid       = 1'b1;
        in_data        = d;
        in_byte_enable = be;
        in_sop         = s;
        in_eop         = e;
        clear_stats    = clr;
        step();
        in_valid    = 1'b0;
        clear_stats = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        st_q.delete();
        m_in_pkt = 0;
        m_len = 0;
        m_bad = 0;
        m_pkt = 0;
        m_err = 0;
        m_orphan = 0;
        m_abort = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_data"}, out_data, 64'(0));
        chk({tag, "_be"}, 64'(out_byte_enable), 64'(0));
        chk({tag, "_sopeop"}, 64'({out_sop, out_eop}), 64'(0));
        chk({tag, "_stat"}, 64'({stat_valid, stat_len, stat_err}), 64'(0));
        chk({tag, "_cnts"}, 64'(pkt_count | err_pkt_count | orphan_count | abort_count), 64'(0));
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_byte_enable = '0;
        in_sop = 1'b0;
        in_eop = 1'b0;
        clear_stats = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        // 13-byte packet
        send(8'hFF, 1, 0);
        send(8'hF8, 0, 1);
        chk("t1_len", 64'(stat_len), 64'(13));
        chk("t1_err", 64'(stat_err), 64'(0));
        chk("t1_pkts", 64'(pkt_count), 64'(1));
        step();

        // single-beat packet
        send(8'h80, 1, 1);
        chk("t2_len", 64'(stat_len), 64'(1));
        chk("t2_err", 64'(stat_err), 64'(0));

        // non-contiguous eop be
        send(8'hFF, 1, 0);
        send(8'hA0, 0, 1);
        chk("t3_len", 64'(stat_len), 64'(10));
        chk("t3_err", 64'(stat_err), 64'(1));
        chk("t3_errpkts", 64'(err_pkt_count), 64'(1));

        // orphan in IDLE
        send(8'hFF, 0, 0);
        chk("t4_outv", 64'(out_valid), 64'(0));
        chk("t4_orphan", 64'(orphan_count), 64'(1));
        step();
        check_counts();

        // abort by sop while in packet
        send(8'hFF, 1, 0);
        send(8'hFF, 0, 0);
        send(8'hFF, 1, 1);
        chk("t5_abort", 64'(abort_count), 64'(1));
        chk("t5_len", 64'(stat_len), 64'(8));
        chk("t5_pkts", 64'(pkt_count), 64'(4));

        // non-eop beat with partial be is bad
        send(8'hFE, 1, 0);
        send(8'hFF, 0, 1);
        chk("t5b_len", 64'(stat_len), 64'(15));
        chk("t5b_err", 64'(stat_err), 64'(1));

        // oversize: 24 bytes with limit 16; exactly 16 is fine
        send(8'hFF, 1, 0);
        send(8'hFF, 0, 0);
        send(8'hFF, 0, 1);
        chk("t6_len", 64'(stat_len), 64'(24));
        chk("t6_err", 64'(stat_err), 64'(2));
        send(8'hFF, 1, 0);
        send(8'hFF, 0, 1);
        chk("t6b_len", 64'(stat_len), 64'(16));
        chk("t6b_err", 64'(stat_err), 64'(0));
        step();
        check_counts();

        // gap cycles keep state; stat holds
        step();
        step();
        chk("hold_len", 64'(stat_len), 64'(16));

        // clear beats a same-cycle orphan increment
        send(8'hFF, 0, 0, 1'b1);
        chk("clr_orphan", 64'(orphan_count), 64'(0));
        check_counts();

        // reset mid-packet
        send(8'hFF, 1, 0);
        send(8'hFF, 0, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hFF, 0, 0);
        chk("rst_orphan", 64'(orphan_count), 64'(1));
        step();
        check_counts();
        chk("q_drained", 64'(exp_q.size() + st_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
